simple_pipe_gen: RTL and testbench

Parametrised successor to the single-channel toggle-and-inverter-chain benchmark cell. It provides WIDTH independent gated toggle channels, each a feedback flop enabled by `inp1 & inp2`, behind a DEPTH-stage output register pipeline that retiming and pipelining experiments can target. It adds a selectable hold mode, a valid qualifier that travels with the data, and a saturating event counter. It sits in the benchmark suite as a scalable timing-analysis and pipelining workload.

---
 rtl/simple_pipe_pkg.sv | 13 +
 rtl/simple_pipe_cell.sv | 18 +
 rtl/simple_pipe_gen.sv | 61 ++++++
 tb/tb_simple_pipe_gen.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/simple_pipe_pkg.sv
// simple_pipe_pkg: mode encoding and per-channel next-state function
package simple_pipe_pkg;

  typedef enum logic {
    MODE_LEGACY = 1'b0,
    MODE_HOLD   = 1'b1
  } mode_t;

  function automatic logic cell_next(input logic en, input logic q, input mode_t mode);
    return (mode == MODE_HOLD) ? (en ? ~q : q) : (en & ~q);
  endfunction

endpackage

// File: rtl/simple_pipe_cell.sv
// simple_pipe_cell: single gated toggle state flop
module simple_pipe_cell
  import simple_pipe_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic valid,
  input  logic mode,
  output logic q
);

  // state advances only on qualified cycles; otherwise it holds
  always_ff @(posedge clk)
    if (!rst_n) q <= 1'b0;
    else if (valid) q <= cell_next(en, q, mode_t'(mode));

endmodule

// File: rtl/simple_pipe_gen.sv
// simple_pipe_gen: WIDTH gated toggle channels behind a DEPTH-stage output pipeline
module simple_pipe_gen
  import simple_pipe_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 3,
  parameter bit INVERT_OUT = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic             tau2015_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             in_valid,
  input  logic             mode,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [CNT_W-1:0] evt_cnt
);

  logic [WIDTH-1:0]            en;
  logic [WIDTH-1:0]            q;
  logic [DEPTH-1:0][WIDTH-1:0] p;
  logic [DEPTH:0]              v;

  assign en = inp1 & inp2;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    simple_pipe_cell u_cell (
      .clk   (tau2015_clk),
      .rst_n (rst_n),
      .en    (en[i]),
      .valid (in_valid),
      .mode  (mode),
      .q     (q[i])
    );
  end

  // free-running data pipeline; no stall, flushed by reset
  always_ff @(posedge tau2015_clk)
    if (!rst_n) p <= '0;
    else begin
      p[0] <= q;
      for (int j = 1; j < DEPTH; j++) p[j] <= p[j-1];
    end

  // valid chain one stage longer than the data pipeline to cover the state flop
  always_ff @(posedge tau2015_clk)
    if (!rst_n) v <= '0;
    else v <= {v[DEPTH-1:0], in_valid};

  // saturating event counter; clear beats increment
  always_ff @(posedge tau2015_clk)
    if (!rst_n || cnt_clr) evt_cnt <= '0;
    else if (in_valid && |en && evt_cnt != '1) evt_cnt <= evt_cnt + CNT_W'(1);

  assign out       = p[DEPTH-1] ^ {WIDTH{INVERT_OUT}};
  assign out_valid = v[DEPTH];

endmodule

// File: tb/tb_simple_pipe_gen.sv
// tb_simple_pipe_gen: directed checks of two configurations sharing one stimulus
module tb_simple_pipe_gen;

  logic       tau2015_clk;
  logic       rst_n;
  logic [3:0] inp1, inp2;
  logic       in_valid, mode, cnt_clr;
  logic [3:0] out1, out2;
  logic       ov1, ov2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  int         checks = 0;
  int         errors = 0;

  simple_pipe_gen #(.WIDTH(4), .DEPTH(3), .INVERT_OUT(1'b1), .CNT_W(8)) dut1 (
    .tau2015_clk(tau2015_clk), .rst_n(rst_n), .inp1(inp1), .inp2(inp2),
    .in_valid(in_valid), .mode(mode), .cnt_clr(cnt_clr),
    .out(out1), .out_valid(ov1), .evt_cnt(cnt1)
  );

  simple_pipe_gen #(.WIDTH(4), .DEPTH(1), .INVERT_OUT(1'b0), .CNT_W(2)) dut2 (
    .tau2015_clk(tau2015_clk), .rst_n(rst_n), .inp1(inp1), .inp2(inp2),
    .in_valid(in_valid), .mode(mode), .cnt_clr(cnt_clr),
    .out(out2), .out_valid(ov2), .evt_cnt(cnt2)
  );

  initial tau2015_clk = 1'b0;
  always #5 tau2015_clk = ~tau2015_clk;

  task automatic tick();
    @(posedge tau2015_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; inp1 = '0; inp2 = '0; mode = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
    checks++; if (out1 !== 4'b1111) begin errors++; $display("FAIL reset_out1 got %b exp 1111", out1); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov1 got %b exp 0", ov1); end
    checks++; if (cnt1 !== 8'd0) begin errors++; $display("FAIL reset_cnt1 got %0d exp 0", cnt1); end
    checks++; if (out2 !== 4'b0000) begin errors++; $display("FAIL reset_out2 got %b exp 0000", out2); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out1 !== 4'b1111 || ov1 !== 1'b0 || cnt1 !== 8'd0) begin
        errors++; $display("FAIL idle_%0d got out=%b ov=%b cnt=%0d exp 1111/0/0", i, out1, ov1, cnt1);
      end
    end
  endtask

  task automatic test_legacy_toggle();
    logic [3:0] eo1 [8] = '{4'b1111, 4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1110, 4'b1111, 4'b1111};
    logic       ev1 [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    logic [7:0] ec1 [8] = '{1, 2, 3, 4, 4, 4, 4, 4};
    logic [3:0] eo2 [8] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic       ev2 [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
    logic [1:0] ec2 [8] = '{1, 2, 3, 3, 3, 3, 3, 3};
    mode = 1'b0; inp1 = 4'b0001; inp2 = 4'b0001;
    for (int e = 0; e < 8; e++) begin
      in_valid = (e < 4);
      tick();
      checks++; if (out1 !== eo1[e]) begin errors++; $display("FAIL toggle_out1[%0d] got %b exp %b", e, out1, eo1[e]); end
      checks++; if (ov1 !== ev1[e]) begin errors++; $display("FAIL toggle_ov1[%0d] got %b exp %b", e, ov1, ev1[e]); end
      checks++; if (cnt1 !== ec1[e]) begin errors++; $display("FAIL toggle_cnt1[%0d] got %0d exp %0d", e, cnt1, ec1[e]); end
      checks++; if (out2 !== eo2[e]) begin errors++; $display("FAIL toggle_out2[%0d] got %b exp %b", e, out2, eo2[e]); end
      checks++; if (ov2 !== ev2[e]) begin errors++; $display("FAIL toggle_ov2[%0d] got %b exp %b", e, ov2, ev2[e]); end
      checks++; if (cnt2 !== ec2[e]) begin errors++; $display("FAIL toggle_cnt2_sat[%0d] got %0d exp %0d", e, cnt2, ec2[e]); end
    end
  endtask

  task automatic test_clear_vs_hold();
    in_valid = 1'b1; mode = 1'b0; inp1 = 4'b0001; inp2 = 4'b0001; tick();
    inp2 = 4'b0000; tick();
    in_valid = 1'b0; tick();
    checks++; if (out2 !== 4'b0000) begin errors++; $display("FAIL legacy_clear got %b exp 0000", out2); end
    in_valid = 1'b1; inp2 = 4'b0001; tick();
    inp2 = 4'b0000; mode = 1'b1; tick();
    in_valid = 1'b0; tick();
    checks++; if (out2 !== 4'b0001) begin errors++; $display("FAIL hold_keep got %b exp 0001", out2); end
    in_valid = 1'b1; inp2 = 4'b0001; tick();
    in_valid = 1'b0; tick();
    checks++; if (out2 !== 4'b0000) begin errors++; $display("FAIL hold_toggle got %b exp 0000", out2); end
    checks++; if (cnt1 !== 8'd7) begin errors++; $display("FAIL clear_hold_cnt1 got %0d exp 7", cnt1); end
  endtask

  task automatic test_valid_gating();
    in_valid = 1'b0; mode = 1'b0; inp1 = 4'b1111; inp2 = 4'b1111;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (out2 !== 4'b0000) begin errors++; $display("FAIL gate_q got %b exp 0000", out2); end
    checks++; if (out1 !== 4'b1111) begin errors++; $display("FAIL gate_out1 got %b exp 1111", out1); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL gate_ov1 got %b exp 0", ov1); end
    checks++; if (cnt1 !== 8'd7) begin errors++; $display("FAIL gate_cnt1 got %0d exp 7", cnt1); end
  endtask

  task automatic test_cnt_clear();
    in_valid = 1'b1; inp1 = 4'b1111; inp2 = 4'b1111; cnt_clr = 1'b1; tick();
    checks++; if (cnt1 !== 8'd0) begin errors++; $display("FAIL clr_wins_cnt1 got %0d exp 0", cnt1); end
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL clr_wins_cnt2 got %0d exp 0", cnt2); end
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (cnt1 !== 8'd5) begin errors++; $display("FAIL recount_cnt1 got %0d exp 5", cnt1); end
    checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL resat_cnt2 got %0d exp 3", cnt2); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1; mode = 1'b0; inp1 = 4'b0001; inp2 = 4'b0001;
    tick(); tick();
    rst_n = 1'b0; tick();
    checks++; if (out1 !== 4'b1111 || ov1 !== 1'b0 || cnt1 !== 8'd0) begin
      errors++; $display("FAIL midrst got out=%b ov=%b cnt=%0d exp 1111/0/0", out1, ov1, cnt1);
    end
    checks++; if (out2 !== 4'b0000 || ov2 !== 1'b0 || cnt2 !== 2'd0) begin
      errors++; $display("FAIL midrst2 got out=%b ov=%b cnt=%0d exp 0000/0/0", out2, ov2, cnt2);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ov1 !== 1'b0 || out1 !== 4'b1111) begin
        errors++; $display("FAIL stale_%0d got out=%b ov=%b exp 1111/0", i, out1, ov1);
      end
    end
  endtask

  task automatic test_first_valid();
    logic ev [5] = '{0, 0, 0, 1, 0};
    rst_n = 1'b0; tick();
    rst_n = 1'b1; in_valid = 1'b1; mode = 1'b0; inp1 = 4'b0011; inp2 = 4'b0011;
    for (int e = 0; e < 5; e++) begin
      tick();
      in_valid = 1'b0;
      checks++; if (ov1 !== ev[e]) begin errors++; $display("FAIL first_ov1[%0d] got %b exp %b", e, ov1, ev[e]); end
      if (e == 3) begin
        checks++; if (out1 !== 4'b1100) begin errors++; $display("FAIL first_out1 got %b exp 1100", out1); end
      end
    end
    checks++; if (cnt1 !== 8'd1) begin errors++; $display("FAIL first_cnt1 got %0d exp 1", cnt1); end
  endtask

  initial begin
    test_reset();
    test_legacy_toggle();
    test_clear_vs_hold();
    test_valid_gating();
    test_cnt_clear();
    test_reset_midstream();
    test_first_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
